// File: rtl/stack_ctrl_pkg.sv
// Shared types and defaults for the stack-side sequencer.
package stack_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 64;
  localparam int unsigned PC_INC_DEF = 4;
  localparam int unsigned OP_W       = 2;

  typedef enum logic [OP_W-1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // PUSH and CALL grow the stack; POP and RET shrink it.
  function automatic logic is_push(input op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Request/response handshake plus stack-memory strobes around stack_ctrl.
interface stack_ctrl_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] req_pc;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  logic              stk_enable;
  logic              stk_push;
  logic              stk_pop;
  logic [DATA_W-1:0] stk_data_in;
  logic [DATA_W-1:0] stk_data_out;
  logic              stk_empty;
  logic [31:0]       stk_pointer;

  // Controller side (the sequencer itself).
  modport slave (
    input  req_valid, req_op, req_data, req_pc, resp_ready,
           stk_data_out, stk_empty, stk_pointer,
    output req_ready, resp_valid, resp_data, resp_err,
           stk_enable, stk_push, stk_pop, stk_data_in
  );

  // Requester and stack-memory side.
  modport master (
    output req_valid, req_op, req_data, req_pc, resp_ready,
           stk_data_out, stk_empty, stk_pointer,
    input  req_ready, resp_valid, resp_data, resp_err,
           stk_enable, stk_push, stk_pop, stk_data_in
  );

endinterface

// File: rtl/stack_ctrl.sv
// Sequencer turning PUSH/POP/CALL/RET requests into one-cycle LIFO strobes.
// Optional full-stack rejection is enabled by defining STACK_CTRL_OVF_CHECK_EN.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned PC_INC = PC_INC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  stack_ctrl_if.slave  bus
);

`ifdef STACK_CTRL_OVF_CHECK_EN
  localparam bit OVF_CHECK = 1'b1;
`else
  localparam bit OVF_CHECK = 1'b0;
`endif

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              stk_enable_q, stk_enable_d;
  logic              stk_push_q, stk_push_d;
  logic              stk_pop_q, stk_pop_d;
  logic [DATA_W-1:0] stk_data_in_q, stk_data_in_d;

  op_e  req_op_c;
  logic full_c;

  assign req_op_c = op_e'(bus.req_op);
  assign full_c   = OVF_CHECK && (bus.stk_pointer == 32'(DEPTH));

  // The stack only moves on our own strobes, so its flags at accept time
  // are still valid during the issue cycle.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    err_d         = err_q;
    req_ready_d   = req_ready_q;
    resp_valid_d  = resp_valid_q;
    resp_err_d    = resp_err_q;
    resp_data_d   = resp_data_q;
    stk_enable_d  = 1'b0;
    stk_push_d    = 1'b0;
    stk_pop_d     = 1'b0;
    stk_data_in_d = stk_data_in_q;

    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          state_d     = ST_ISSUE;
          req_ready_d = 1'b0;
          op_d        = req_op_c;
          data_d      = bus.req_data;
          err_d       = is_push(req_op_c) ? full_c : bus.stk_empty;
          if (is_push(req_op_c)) begin
            stk_data_in_d = (req_op_c == OP_CALL)
                          ? DATA_W'(bus.req_pc + DATA_W'(PC_INC))
                          : bus.req_data;
          end
          if (!err_d) begin
            stk_enable_d = 1'b1;
            stk_push_d   = is_push(req_op_c);
            stk_pop_d    = !is_push(req_op_c);
          end
        end
      end
      ST_ISSUE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        // Top of stack is sampled before the pop strobe moves the pointer.
        resp_data_d  = is_push(op_q) ? data_q : bus.stk_data_out;
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_PUSH;
      data_q        <= '0;
      err_q         <= 1'b0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
      stk_enable_q  <= 1'b0;
      stk_push_q    <= 1'b0;
      stk_pop_q     <= 1'b0;
      stk_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      err_q         <= err_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_data_q   <= resp_data_d;
      stk_enable_q  <= stk_enable_d;
      stk_push_q    <= stk_push_d;
      stk_pop_q     <= stk_pop_d;
      stk_data_in_q <= stk_data_in_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.stk_enable  = stk_enable_q;
  assign bus.stk_push    = stk_push_q;
  assign bus.stk_pop     = stk_pop_q;
  assign bus.stk_data_in = stk_data_in_q;

endmodule
